// File: rtl/pio_loader.sv
// pio_loader: streams a PIO program from RAM into pio, then configures one SM.
// Define PIO_LOADER_SIDES_EN to insert the side-set (SIDES) step before enable.
module pio_loader #(
    parameter int MEM_AW = 5,
    parameter int MIW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        plen,
    input  logic [MIW-1:0]    cfg_mindex,
    input  logic [23:0]       cfg_div,
    input  logic [31:0]       cfg_grps,
    input  logic [31:0]       cfg_en,
    input  logic [31:0]       cfg_sides,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [3:0]        action,
    output logic [4:0]        index,
    output logic [MIW-1:0]    mindex,
    output logic [31:0]       din,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PRIME = 4'd1;
    localparam logic [3:0] S_LOAD  = 4'd2;
    localparam logic [3:0] S_PEND  = 4'd3;
    localparam logic [3:0] S_DIV   = 4'd4;
    localparam logic [3:0] S_GRPS  = 4'd5;
    localparam logic [3:0] S_EN    = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [3:0] A_NONE  = 4'd0;
    localparam logic [3:0] A_INSTR = 4'd1;
    localparam logic [3:0] A_PEND  = 4'd2;
    localparam logic [3:0] A_GRPS  = 4'd5;
    localparam logic [3:0] A_EN    = 4'd6;
    localparam logic [3:0] A_DIV   = 4'd7;

    localparam logic [6:0] MAXLEN  = 7'(2 ** MEM_AW);

`ifdef PIO_LOADER_SIDES_EN
    localparam logic [3:0] S_SIDES = 4'd6;
    localparam logic [3:0] A_SIDES = 4'd8;
    logic [31:0] sides_q, sides_d;
`else
    logic unused_sides;
    assign unused_sides = ^cfg_sides;
`endif

    logic [3:0]        state_q, state_d;
    logic [MEM_AW-1:0] cnt_q, cnt_d;
    logic [5:0]        plen_q, plen_d;
    logic [23:0]       div_q, div_d;
    logic [31:0]       grps_q, grps_d;
    logic [31:0]       en_q, en_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [3:0]        action_q, action_d;
    logic [4:0]        index_q, index_d;
    logic [MIW-1:0]    mindex_q, mindex_d;
    logic [31:0]       din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic       plen_ok;
    logic       last;
    logic [6:0] ahead;
    logic [5:0] lastk;

    assign plen_ok = (plen != 6'd0) && ({1'b0, plen} <= MAXLEN);
    assign lastk   = plen_q - 6'd1;
    assign last    = (6'(cnt_q) == lastk);
    assign ahead   = 7'(cnt_q) + 7'd2;

    // Sequencer next-state: one action per cycle, RAM address kept one ahead.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        plen_d   = plen_q;
        div_d    = div_q;
        grps_d   = grps_q;
        en_d     = en_q;
        addr_d   = addr_q;
        action_d = action_q;
        index_d  = index_q;
        mindex_d = mindex_q;
        din_d    = din_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef PIO_LOADER_SIDES_EN
        sides_d  = sides_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                action_d = A_NONE;
                // done_q marks the DONE cycle; a start there is dropped
                if (start && !done_q) begin
                    if (plen_ok) begin
                        plen_d   = plen;
                        div_d    = cfg_div;
                        grps_d   = cfg_grps;
                        en_d     = cfg_en;
                        mindex_d = cfg_mindex;
`ifdef PIO_LOADER_SIDES_EN
                        sides_d  = cfg_sides;
`endif
                        addr_d   = '0;
                        busy_d   = 1'b1;
                        state_d  = S_PRIME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PRIME: begin
                action_d = A_NONE;
                cnt_d    = '0;
                addr_d   = (plen_q == 6'd1) ? '0 : MEM_AW'(1);
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                action_d = A_INSTR;
                index_d  = 5'(cnt_q);
                din_d    = {16'h0, mem_rdata};
                cnt_d    = cnt_q + 1'b1;
                if (ahead <= {1'b0, lastk}) begin
                    addr_d = MEM_AW'(ahead);
                end else begin
                    addr_d = MEM_AW'(lastk);
                end
                if (last) begin
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                action_d = A_PEND;
                din_d    = 32'(lastk);
                state_d  = S_DIV;
            end
            S_DIV: begin
                action_d = A_DIV;
                din_d    = {8'h0, div_q};
                state_d  = S_GRPS;
            end
            S_GRPS: begin
                action_d = A_GRPS;
                din_d    = grps_q;
`ifdef PIO_LOADER_SIDES_EN
                state_d  = S_SIDES;
`else
                state_d  = S_EN;
`endif
            end
`ifdef PIO_LOADER_SIDES_EN
            S_SIDES: begin
                action_d = A_SIDES;
                din_d    = sides_q;
                state_d  = S_EN;
            end
`endif
            S_EN: begin
                action_d = A_EN;
                din_d    = en_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                action_d = A_NONE;
                din_d    = '0;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                action_d = A_NONE;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any sequence at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            plen_q   <= '0;
            div_q    <= '0;
            grps_q   <= '0;
            en_q     <= '0;
            addr_q   <= '0;
            action_q <= A_NONE;
            index_q  <= '0;
            mindex_q <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef PIO_LOADER_SIDES_EN
            sides_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            plen_q   <= plen_d;
            div_q    <= div_d;
            grps_q   <= grps_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            action_q <= action_d;
            index_q  <= index_d;
            mindex_q <= mindex_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef PIO_LOADER_SIDES_EN
            sides_q  <= sides_d;
`endif
        end
    end

    assign mem_addr = addr_q;
    assign action   = action_q;
    assign index    = index_q;
    assign mindex   = mindex_q;
    assign din      = din_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
